// File: rtl/phase_meas_sched.sv
`timescale 1ns/1ps
// Measurement scheduler: per enabled channel pair runs clear, gate window, settle, latch,
// then offers the captured count on a valid/ready port before moving to the next pair.
module phase_meas_sched #(
  parameter int GATE_CYCLES   = 100_000_000,
  parameter int SETTLE_CYCLES = 10,
  parameter int NUM_PAIRS     = 4,
  parameter int SEL_W         = 2
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 continuous,
  input  logic [NUM_PAIRS-1:0] pair_mask,
  input  logic [31:0]          cnt_in,
  output logic                 gate,
  output logic                 clr,
  output logic                 latch,
  output logic [SEL_W-1:0]     pair_sel,
  output logic [31:0]          result_data,
  output logic [SEL_W-1:0]     result_pair,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic                 busy,
  output logic                 scan_done
);

  typedef enum logic [2:0] {IDLE, CLEAR, GATE, SETTLE, LATCH, OUTPUT} state_t;

  state_t               state;
  logic [NUM_PAIRS-1:0] mask_r;
  logic [31:0]          gate_cnt;
  logic [31:0]          settle_cnt;
  logic [SEL_W:0]       nxt;

  function automatic logic [SEL_W-1:0] lowest_bit(input logic [NUM_PAIRS-1:0] m);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = NUM_PAIRS - 1; i >= 0; i--)
      if (m[i]) idx = SEL_W'(i);
    return idx;
  endfunction

  // Returns {found, index} of the lowest set bit strictly above cur.
  function automatic logic [SEL_W:0] next_bit(input logic [NUM_PAIRS-1:0] m,
                                              input logic [SEL_W-1:0] cur);
    logic [SEL_W-1:0] idx;
    logic             found;
    idx   = '0;
    found = 1'b0;
    for (int i = NUM_PAIRS - 1; i >= 0; i--)
      if (m[i] && (i > int'(cur))) begin
        found = 1'b1;
        idx   = SEL_W'(i);
      end
    return {found, idx};
  endfunction

  assign nxt = next_bit(mask_r, pair_sel);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      mask_r       <= '0;
      gate_cnt     <= '0;
      settle_cnt   <= '0;
      gate         <= 1'b0;
      clr          <= 1'b0;
      latch        <= 1'b0;
      pair_sel     <= '0;
      result_data  <= '0;
      result_pair  <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      scan_done    <= 1'b0;
    end else if (abort) begin
      // Abort wins over start and over a handshake in the same cycle.
      state        <= IDLE;
      gate         <= 1'b0;
      clr          <= 1'b0;
      latch        <= 1'b0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      scan_done    <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && (pair_mask != '0)) begin
            mask_r   <= pair_mask;
            pair_sel <= lowest_bit(pair_mask);
            clr      <= 1'b1;
            busy     <= 1'b1;
            state    <= CLEAR;
          end
        end
        CLEAR: begin
          clr      <= 1'b0;
          gate     <= 1'b1;
          gate_cnt <= 32'(GATE_CYCLES - 1);
          state    <= GATE;
        end
        GATE: begin
          if (gate_cnt == '0) begin
            gate       <= 1'b0;
            settle_cnt <= 32'(SETTLE_CYCLES - 1);
            state      <= SETTLE;
          end else begin
            gate_cnt <= gate_cnt - 32'd1;
          end
        end
        SETTLE: begin
          if (settle_cnt == '0) begin
            latch <= 1'b1;
            state <= LATCH;
          end else begin
            settle_cnt <= settle_cnt - 32'd1;
          end
        end
        LATCH: begin
          latch        <= 1'b0;
          result_data  <= cnt_in;
          result_pair  <= pair_sel;
          result_valid <= 1'b1;
          state        <= OUTPUT;
        end
        OUTPUT: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            if (nxt[SEL_W]) begin
              pair_sel <= nxt[SEL_W-1:0];
              clr      <= 1'b1;
              state    <= CLEAR;
            end else if (continuous) begin
              pair_sel <= lowest_bit(mask_r);
              clr      <= 1'b1;
              state    <= CLEAR;
            end else begin
              busy      <= 1'b0;
              scan_done <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_phase_meas_sched.sv
`timescale 1ns/1ps
// Directed bench for phase_meas_sched with a short gate (8) and settle (2) window.
module tb_phase_meas_sched;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic        start, abort, continuous;
  logic [3:0]  pair_mask;
  logic [31:0] cnt_in;
  logic        gate, clr, latch;
  logic [1:0]  pair_sel;
  logic [31:0] result_data;
  logic [1:0]  result_pair;
  logic        result_valid, result_ready, busy, scan_done;

  int total = 0;
  int bad   = 0;

  phase_meas_sched #(
    .GATE_CYCLES(8), .SETTLE_CYCLES(2), .NUM_PAIRS(4), .SEL_W(2)
  ) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .start(start), .abort(abort),
    .continuous(continuous), .pair_mask(pair_mask), .cnt_in(cnt_in),
    .gate(gate), .clr(clr), .latch(latch), .pair_sel(pair_sel),
    .result_data(result_data), .result_pair(result_pair),
    .result_valid(result_valid), .result_ready(result_ready),
    .busy(busy), .scan_done(scan_done)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; abort = 0; continuous = 0;
    pair_mask = '0; cnt_in = '0; result_ready = 1'b1;
    tick(); tick();
    total++;
    if ({gate, clr, latch, pair_sel, result_data, result_pair, result_valid, busy, scan_done} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: gate=%b clr=%b latch=%b valid=%b busy=%b done=%b data=%h required all 0",
               gate, clr, latch, result_valid, busy, scan_done, result_data);
    end
    #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [5:0] exp, got;
    pair_mask = 4'b0001; cnt_in = 32'd5; result_ready = 1'b1; continuous = 0; start = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      tick();
      start = 1'b0;
      exp = {c == 1, (c >= 2) && (c <= 9), c == 12, c == 13, c == 14, (c >= 1) && (c <= 13)};
      got = {clr, gate, latch, result_valid, scan_done, busy};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL single_timing cycle %0d: {clr,gate,latch,valid,done,busy}=%b required %b", c, got, exp);
      end
      if (c == 13) begin
        total++;
        if (result_data !== 32'd5 || result_pair !== 2'd0) begin
          bad++;
          $display("FAIL single_result: data=%0d pair=%0d required 5 0", result_data, result_pair);
        end
      end
    end
  endtask

  task automatic test_two_pairs();
    int clr_n = 0, gate_n = 0, done_n = 0, res_n = 0, sel_change = 0;
    logic [1:0]  pairs [2];
    logic [31:0] datas [2];
    logic [1:0]  prev_sel;
    pair_mask = 4'b1010; continuous = 0; result_ready = 1'b1; cnt_in = 32'd1000; start = 1'b1;
    prev_sel = pair_sel;
    for (int c = 1; c <= 28; c++) begin
      tick();
      start = 1'b0;
      cnt_in = 32'd1000 + 32'(c);
      if (clr) clr_n++;
      if (gate) begin
        gate_n++;
        if (pair_sel !== prev_sel) sel_change++;
      end
      if (scan_done) done_n++;
      if (result_valid) begin
        if (res_n < 2) begin pairs[res_n] = result_pair; datas[res_n] = result_data; end
        res_n++;
      end
      prev_sel = pair_sel;
    end
    total++;
    if (clr_n != 2 || gate_n != 16 || done_n != 1 || res_n != 2) begin
      bad++;
      $display("FAIL two_pairs_counts: clr=%0d gate=%0d done=%0d results=%0d required 2 16 1 2",
               clr_n, gate_n, done_n, res_n);
    end
    total++;
    if (res_n == 2 && (pairs[0] !== 2'd1 || pairs[1] !== 2'd3 ||
                       datas[0] !== 32'd1012 || datas[1] !== 32'd1025)) begin
      bad++;
      $display("FAIL two_pairs_results: pairs=%0d,%0d data=%0d,%0d required 1,3 1012,1025",
               pairs[0], pairs[1], datas[0], datas[1]);
    end
    total++;
    if (sel_change != 0) begin
      bad++;
      $display("FAIL two_pairs_sel_stable: pair_sel changed %0d times during gate, required 0", sel_change);
    end
  endtask

  task automatic test_backpressure();
    int held_bad = 0;
    pair_mask = 4'b0011; continuous = 0; result_ready = 1'b0; cnt_in = 32'd7; start = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      tick();
      start = 1'b0;
    end
    total++;
    if (result_valid !== 1'b1 || result_data !== 32'd7 || result_pair !== 2'd0) begin
      bad++;
      $display("FAIL bp_first: valid=%b data=%0d pair=%0d required 1 7 0", result_valid, result_data, result_pair);
    end
    for (int i = 1; i <= 20; i++) begin
      cnt_in = 32'd50 + 32'(i);
      tick();
      if (result_valid !== 1'b1 || result_data !== 32'd7 || clr !== 1'b0) held_bad++;
    end
    total++;
    if (held_bad != 0) begin
      bad++;
      $display("FAIL bp_hold: %0d cycles lost valid/data or cleared early, required 0", held_bad);
    end
    result_ready = 1'b1;
    tick();
    total++;
    if (clr !== 1'b1 || result_valid !== 1'b0 || pair_sel !== 2'd1) begin
      bad++;
      $display("FAIL bp_release: clr=%b valid=%b pair_sel=%0d required 1 0 1", clr, result_valid, pair_sel);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++;
    if (busy !== 1'b0 || clr !== 1'b0) begin
      bad++;
      $display("FAIL bp_cleanup_abort: busy=%b clr=%b required 0 0", busy, clr);
    end
  endtask

  task automatic test_continuous();
    int rv_cyc [3];
    int rv_n = 0, done_cyc = -1, pair_bad = 0;
    pair_mask = 4'b0100; continuous = 1'b1; result_ready = 1'b1; cnt_in = 32'd9; start = 1'b1;
    for (int c = 1; c <= 42; c++) begin
      tick();
      start = 1'b0;
      if (c == 30) continuous = 1'b0;
      if (result_valid) begin
        if (rv_n < 3) rv_cyc[rv_n] = c;
        if (result_pair !== 2'd2) pair_bad++;
        rv_n++;
      end
      if (scan_done) done_cyc = c;
    end
    total++;
    if (rv_n != 3 || rv_cyc[0] != 13 || rv_cyc[1] != 26 || rv_cyc[2] != 39) begin
      bad++;
      $display("FAIL cont_period: results=%0d at %0d,%0d,%0d required 3 at 13,26,39",
               rv_n, rv_cyc[0], rv_cyc[1], rv_cyc[2]);
    end
    total++;
    if (done_cyc != 40 || pair_bad != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL cont_stop: scan_done at %0d pair_errs=%0d busy=%b required 40 0 0", done_cyc, pair_bad, busy);
    end
  endtask

  task automatic test_abort();
    int stray = 0;
    pair_mask = 4'b0001; continuous = 0; result_ready = 1'b1; start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      start = 1'b0;
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++;
    if (gate !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_immediate: gate=%b busy=%b required 0 0", gate, busy);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (result_valid || scan_done || busy || gate) stray++;
    end
    total++;
    if (stray != 0) begin
      bad++;
      $display("FAIL abort_quiet: %0d cycles with activity after abort, required 0", stray);
    end
    pair_mask = 4'b0000; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (busy || clr) stray++;
    end
    start = 1'b0;
    total++;
    if (stray != 0) begin
      bad++;
      $display("FAIL empty_mask_start: %0d busy/clr cycles, required 0", stray);
    end
  endtask

  task automatic test_reset_mid();
    pair_mask = 4'b0001; result_ready = 1'b1; start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      start = 1'b0;
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({gate, clr, latch, pair_sel, result_data, result_pair, result_valid, busy, scan_done} !== '0) begin
      bad++;
      $display("FAIL reset_in_gate: gate=%b busy=%b valid=%b required all 0", gate, busy, result_valid);
    end
    tick();
    #1 rst_n = 1'b1;
    result_ready = 1'b0; cnt_in = 32'd3; start = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      tick();
      start = 1'b0;
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({gate, clr, latch, pair_sel, result_data, result_pair, result_valid, busy, scan_done} !== '0) begin
      bad++;
      $display("FAIL reset_in_output: valid=%b data=%0d busy=%b required all 0", result_valid, result_data, busy);
    end
    tick();
    #1 rst_n = 1'b1;
    result_ready = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_pairs();
    test_backpressure();
    test_continuous();
    test_abort();
    test_reset_mid();
    test_single();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/phase_meas_sched.md
Name: phase_meas_sched

Overview:
- Measurement scheduler for the gated phase/frequency counting datapath.
- Sequences per-channel-pair measurements: clear, fixed gate window, settle, latch.
- Steps through the enabled channel pairs and hands each 32-bit count to a downstream consumer (display/UART) over a valid/ready handshake.
- Sits between the counter datapath (which counts while gate is high) and the reporting logic.

Parameters:
GATE_CYCLES, 100_000_000, sys_clk cycles gate is held high per measurement (>=1)
SETTLE_CYCLES, 10, cycles between gate fall and latch, lets edge-detect pipeline drain (>=1)
NUM_PAIRS, 4, number of selectable channel pairs (2..16)
SEL_W, 2, width of pair_sel, equals clog2(NUM_PAIRS)

Ports:
sys_clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request a scan, sampled in IDLE only
abort  in  1  synchronous abort, any state
continuous  in  1  sampled at end of each scan: 1 = rescan, 0 = stop
pair_mask  in  NUM_PAIRS  enabled pairs, captured on accepted start
cnt_in  in  32  counter value from datapath
gate  out  1  datapath count enable
clr  out  1  one-cycle datapath counter clear
latch  out  1  one-cycle capture strobe
pair_sel  out  SEL_W  pair currently routed to datapath
result_data  out  32  captured count
result_pair  out  SEL_W  pair index of result_data
result_valid  out  1  result available
result_ready  in  1  consumer accepts result
busy  out  1  high in any state except IDLE
scan_done  out  1  one-cycle pulse on completion of a non-continuous scan

Behaviour:
- All outputs registered. Reset values: all outputs 0; FSM IDLE; mask_r 0; gate and settle counters 0.
- FSM states: IDLE, CLEAR, GATE, SETTLE, LATCH, OUTPUT.
- IDLE: start=1 with pair_mask!=0 -> capture mask_r, pair_sel = lowest set bit, go to CLEAR. start with pair_mask==0 is ignored: stay IDLE, busy stays 0.
- CLEAR: clr=1 for exactly 1 cycle -> GATE.
- GATE: gate=1 for exactly GATE_CYCLES consecutive cycles; 32-bit down-counter -> SETTLE.
- SETTLE: gate=0 for SETTLE_CYCLES cycles -> LATCH.
- LATCH: latch=1 for 1 cycle; result_data <= cnt_in and result_pair <= pair_sel on the edge leaving LATCH -> OUTPUT.
- OUTPUT: result_valid=1; data and pair stable until handshake. On result_valid&&result_ready:
  - next higher set bit in mask_r exists -> pair_sel = that bit, go to CLEAR;
  - else continuous=1 -> pair_sel = lowest set bit of mask_r, CLEAR;
  - else -> IDLE with scan_done=1 for one cycle.
- result_valid falls the cycle after the handshake.
- Latency from accepted start to first result_valid: 1+GATE_CYCLES+SETTLE_CYCLES+1+1 cycles.
- pair_sel changes only on entry to CLEAR; it is never changed while gate=1.
- pair_mask changes mid-scan are ignored; the new mask takes effect at the next start.
- abort=1: next cycle FSM=IDLE; gate, clr, latch, result_valid, busy = 0; no scan_done. abort has priority over start and over a simultaneous handshake.
- rst_n low mid-gate: gate drops asynchronously; all state returns to reset values.
- result_ready is ignored outside OUTPUT.
- Single-bit mask: continuous mode re-measures the same pair back-to-back.

Test Plan:
1. GATE_CYCLES=8, SETTLE_CYCLES=2, mask=4'b0001, start at cycle 0, cnt_in=32'd5, result_ready=1 -> clr at cycle 1; gate cycles 2-9; latch cycle 12; result_valid cycle 13 with data 5, pair 0; scan_done cycle 14; busy 1-13.
2. mask=4'b1010, continuous=0, result_ready=1 -> two results, result_pair 1 then 3, each preceded by one clr and 8 gate cycles; one scan_done; pair_sel never changes while gate=1.
3. Backpressure: result_ready held 0 for 20 cycles in OUTPUT, cnt_in changed meanwhile -> result_valid held, result_data unchanged; next clr occurs the cycle after result_ready rises.
4. continuous=1, mask=4'b0100 -> repeated results, pair 2, result_valid period = 13 cycles with ready=1; dropping continuous mid-gate -> scan ends after the current result with scan_done.
5. abort asserted on gate cycle 4 -> gate 0 next cycle, busy 0, no result_valid, no scan_done; start with mask=0 -> stays IDLE.
6. rst_n pulsed low during GATE and during OUTPUT -> gate and result_valid drop immediately; all outputs 0; a fresh start behaves as in test 1.
